parking_sensor_gen: RTL and testbench
=====================================

PARKING_SENSOR_GEN -- requirements
Module: parking_sensor_gen

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: clocks each non-idle sensor phase is held; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1: clocks of a=0,b=0 after the last phase; legal range 1..255.
REQ-003 Parameter MAX_CARS, default 7: occupancy ceiling for the shadow counter; legal range 1..7.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  a car-transit request is offered.
REQ-007 req_exit  input  1  request direction: 0 = entry, 1 = exit; sampled with req_valid.
REQ-008 req_ready  output  1  generator is idle and accepts a request.
REQ-009 a, b  output  1 each  registered sensor drives toward the parking-lot counter.
REQ-010 busy  output  1  a sequence is in progress.
REQ-011 done  output  1  one-cycle pulse when a sequence completes.
REQ-012 exp_count  output  3  expected counter value after all completed sequences.

Function
REQ-013 States: IDLE, P1, P2, P3, GAP; the request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-014 Entry phases are P1=(a1,b0), P2=(a1,b1), P3=(a0,b1); exit phases are P1=(a0,b1), P2=(a1,b1), P3=(a1,b0); GAP and IDLE drive (a0,b0).
REQ-015 The first phase value appears on a/b in the cycle after acceptance (latency 1).
REQ-016 Each of P1..P3 lasts exactly HOLD_CYCLES clocks; GAP lasts exactly GAP_CYCLES clocks; the FSM then returns to IDLE.
REQ-017 req_ready is 1 only in IDLE; busy is the exact complement of req_ready.
REQ-018 req_valid while busy is ignored, and no request is queued.
REQ-019 req_exit is latched at acceptance; later changes to req_exit have no effect on the running sequence.
REQ-020 done pulses for 1 clock on the final GAP cycle, and exp_count updates on the same edge that ends GAP.
REQ-021 A completed entry increments exp_count, saturating at MAX_CARS; a completed exit decrements it, saturating at 0.
REQ-022 The a/b sequence is always emitted in full, even when exp_count is saturated.
REQ-023 a and b never both change in the same clock (Gray-ordered transitions).
REQ-024 The phase timer is 8 bits wide, reloads on every state change, and never wraps.

Reset
REQ-025 While reset_n=0: state=IDLE, a=0, b=0, req_ready=1, busy=0, done=0, exp_count=0, timer=0.
REQ-026 A reset asserted mid-sequence forces a=b=0 immediately (asynchronous) and discards the sequence without updating exp_count.
REQ-027 The first acceptance after reset release is possible on the first rising edge with reset_n=1.

Configuration
REQ-028 Macro PARKING_SENSOR_GEN_ABORT_EN, when defined, adds input abort (1 bit) and output aborted (1 bit, one-cycle pulse).
REQ-029 With the macro defined, abort=1 in P3 steps the FSM back P3->P2->P1->GAP, each step held HOLD_CYCLES.
REQ-030 With the macro defined, abort=1 in P2 steps back P2->P1->GAP, and abort=1 in P1 goes directly to GAP.
REQ-031 An aborted sequence pulses both done and aborted at the end of GAP and leaves exp_count unchanged; abort in IDLE or GAP is ignored.
REQ-032 Without the macro, the abort and aborted ports do not exist and behaviour is exactly REQ-013..REQ-024.

Structure
REQ-033 Shared package parking_pkg holds the phase-state enum, the CNT_W=3 constant, and the entry/exit phase-to-(a,b) lookup constants.
REQ-034 One sub-module, psg_phase_timer (loadable 8-bit down-counter with a zero flag), is instantiated once.

Verification
REQ-035 Reset, then entry request with HOLD=1, GAP=1 -> a/b = 10,11,01,00 on cycles 1..4; done at cycle 4; exp_count 0->1.
REQ-036 Exit request at exp_count=1 -> a/b = 01,11,10,00; exp_count 1->0. A second exit -> same waveform; exp_count stays 0.
REQ-037 Eight back-to-back entries -> exp_count = 1..7, then stays 7; req_ready=0 and req_valid ignored in every busy cycle.
REQ-038 HOLD_CYCLES=3, GAP_CYCLES=2 entry -> each phase held 3 clocks, 00 held 2 clocks, done 11 clocks after acceptance.
REQ-039 reset_n low during P2 -> a=b=0 without waiting for clk; exp_count=0; req_ready=1.
REQ-040 With PARKING_SENSOR_GEN_ABORT_EN, abort during entry P3 -> a/b = 10,11,01,11,10,00; done and aborted pulse together; exp_count unchanged.

Source files
------------

// File: rtl/parking_pkg.sv
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared types and constants for the parking sensor generator:
//                phase-state enum, counter width, timer width and the
//                entry/exit phase-to-(a,b) lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int CNT_W = 3;
    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_GAP  = 3'd4
    } psg_state_e;

    // {a,b} per phase; entry and exit walk the same Gray path in opposite order
    localparam logic [1:0] c_ENTRY_P1_AB = 2'b10;
    localparam logic [1:0] c_ENTRY_P2_AB = 2'b11;
    localparam logic [1:0] c_ENTRY_P3_AB = 2'b01;
    localparam logic [1:0] c_EXIT_P1_AB  = 2'b01;
    localparam logic [1:0] c_EXIT_P2_AB  = 2'b11;
    localparam logic [1:0] c_EXIT_P3_AB  = 2'b10;

    function automatic logic [1:0] phase_ab(input psg_state_e st, input logic is_exit);
        logic [1:0] ab;
        ab = 2'b00;
        case (st)
            ST_P1:   ab = is_exit ? c_EXIT_P1_AB : c_ENTRY_P1_AB;
            ST_P2:   ab = is_exit ? c_EXIT_P2_AB : c_ENTRY_P2_AB;
            ST_P3:   ab = is_exit ? c_EXIT_P3_AB : c_ENTRY_P3_AB;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

`default_nettype wire

// File: rtl/psg_phase_timer.sv
// ============================================================================
//  Module      : psg_phase_timer
//  Description : Loadable down-counter for phase durations. Stops at zero
//                (never wraps) and flags when it has reached zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psg_phase_timer
    import parking_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/parking_sensor_gen.sv
// ============================================================================
//  Module      : parking_sensor_gen
//  Description : Generates Gray-ordered a/b sensor waveforms for car entry and
//                exit transits and tracks the expected lot occupancy.
//                Optional abort feature: define PARKING_SENSOR_GEN_ABORT_EN to
//                add the abort input and aborted output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_sensor_gen
    import parking_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int MAX_CARS    = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_exit,
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             req_ready,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp_count
);

    localparam logic [TMR_W-1:0] c_HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_GAP_LD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_CARS);

    psg_state_e       r_state;
    psg_state_e       w_next;
    logic             r_a;
    logic             r_b;
    logic             r_exit;
    logic             r_abrt;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_abort_in;
    logic             w_new_abort;
    logic             w_zero;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_dir;
    logic [1:0]       w_ab;

`ifdef PARKING_SENSOR_GEN_ABORT_EN
    assign w_abort_in = abort;
    assign aborted    = done && r_abrt;
`else
    assign w_abort_in = 1'b0;
`endif

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = !req_ready;
    assign w_accept  = req_valid && req_ready;
    assign done      = (r_state == ST_GAP) && w_zero;
    assign a         = r_a;
    assign b         = r_b;
    assign exp_count = r_count;

    // Direction of the sequence: live input on acceptance, latched value after
    assign w_dir = w_accept ? req_exit : r_exit;
    assign w_ab  = phase_ab(w_next, w_dir);

    // Next-state: forward walk, or backward walk once an abort has been taken
    always_comb begin
        w_next      = r_state;
        w_new_abort = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_P1;
            ST_P1: begin
                if (w_abort_in && !r_abrt) begin
                    w_next      = ST_GAP;
                    w_new_abort = 1'b1;
                end else if (w_zero) begin
                    w_next = r_abrt ? ST_GAP : ST_P2;
                end
            end
            ST_P2: begin
                if (w_abort_in && !r_abrt) begin
                    w_next      = ST_P1;
                    w_new_abort = 1'b1;
                end else if (w_zero) begin
                    w_next = r_abrt ? ST_P1 : ST_P3;
                end
            end
            ST_P3: begin
                if (w_abort_in && !r_abrt) begin
                    w_next      = ST_P2;
                    w_new_abort = 1'b1;
                end else if (w_zero) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP:  if (w_zero) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Timer reloads with the duration of whichever state is being entered
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = '0;
        case (w_next)
            ST_P1, ST_P2, ST_P3: w_load_val = c_HOLD_LD;
            ST_GAP:              w_load_val = c_GAP_LD;
            default:             w_load_val = '0;
        endcase
    end

    psg_phase_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // State, registered sensor drives, latched direction and abort flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_exit  <= 1'b0;
            r_abrt  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_a     <= w_ab[1];
            r_b     <= w_ab[0];
            if (w_accept) begin
                r_exit <= req_exit;
                r_abrt <= 1'b0;
            end else if (w_new_abort) begin
                r_abrt <= 1'b1;
            end
        end
    end

    // Occupancy shadow: saturating update on the edge that ends a clean GAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (done && !r_abrt) begin
            if (!r_exit) begin
                if (r_count < c_MAX_CNT) r_count <= r_count + 1'b1;
            end else begin
                if (r_count != '0) r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_parking_sensor_gen.sv
// ============================================================================
//  Module      : tb_parking_sensor_gen
//  Description : Self-checking bench for parking_sensor_gen with a scoreboard
//                and a behavioural occupancy/waveform reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_sensor_gen;

    localparam int H   = 3;
    localparam int G   = 2;
    localparam int MAX = 7;
    localparam int SEQ = 3 * H + G;

    typedef struct {
        logic ex;
        int   cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_exit = 1'b0;
    logic       req_ready;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [2:0] exp_count;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    parking_sensor_gen #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .MAX_CARS    (MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_exit  (req_exit),
`ifdef PARKING_SENSOR_GEN_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .exp_count (exp_count)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t exq[$];
    int   left    = 0;   // model: busy cycles remaining after the next edge
    int   cur_left = 0;  // model: busy cycles remaining in the displayed cycle
    int   mcount  = 0;
    bit   rst_seen = 1'b1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    // One clock of stimulus: check handshake against the model, then drive
    task automatic step(input logic v, input logic ex);
        exp_t e;
        @(negedge clk);
        cur_left = left;
        chk(req_ready === (left == 0), "req_ready", int'(req_ready), int'(left == 0));
        chk(busy === (left != 0), "busy", int'(busy), int'(left != 0));
        req_valid = v;
        req_exit  = ex;
        if (left == 0 && v) begin
            if (ex) mcount = (mcount > 0) ? mcount - 1 : 0;
            else    mcount = (mcount < MAX) ? mcount + 1 : MAX;
            e.ex  = ex;
            e.cnt = mcount;
            exq.push_back(e);
            left = SEQ;
        end else if (left > 0) begin
            left--;
        end
    endtask

    task automatic busy_random();
        while (left != 0) step(1'($urandom), 1'($urandom));
    endtask

    task automatic reset_mid();
        #2;
        reset_n  = 1'b0;
        rst_seen = 1'b1;
        #1;
        chk({a, b} === 2'b00, "async_ab", int'({a, b}), 0);
        chk(req_ready === 1'b1, "rst_ready", int'(req_ready), 1);
        chk(busy === 1'b0, "rst_busy", int'(busy), 0);
        chk(done === 1'b0, "rst_done", int'(done), 0);
        chk(exp_count === 3'd0, "rst_count", int'(exp_count), 0);
        exq.delete();
        left      = 0;
        mcount    = 0;
        req_valid = 1'b0;
        #4;
        reset_n = 1'b1;
    endtask

    // Stimulus and reference model
    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({a, b} === 2'b00, "reset_ab", int'({a, b}), 0);
        chk(req_ready === 1'b1, "reset_ready", int'(req_ready), 1);
        chk(busy === 1'b0, "reset_busy", int'(busy), 0);
        chk(done === 1'b0, "reset_done", int'(done), 0);
        chk(exp_count === 3'd0, "reset_count", int'(exp_count), 0);
        // Request offered while still in reset; first edge after release accepts
        req_valid = 1'b1;
        req_exit  = 1'b0;
        mcount    = 1;
        e.ex = 1'b0; e.cnt = 1;
        exq.push_back(e);
        left = SEQ;
        #2 reset_n = 1'b1;
        busy_random();
        // Exit, then exit at zero (saturates)
        step(1'b1, 1'b1); busy_random();
        step(1'b1, 1'b1); busy_random();
        // Back-to-back entries past the ceiling, then exits past zero
        repeat (9 * (SEQ + 1)) step(1'b1, 1'b0);
        busy_random();
        repeat (9 * (SEQ + 1)) step(1'b1, 1'b1);
        busy_random();
        // Random traffic
        repeat (400) step(1'($urandom_range(0, 2) != 0), 1'($urandom));
        busy_random();
        // Reset during P2 of an entry
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        while (!(cur_left <= SEQ - H && cur_left > SEQ - 2 * H)) step(1'b0, 1'b1);
        reset_mid();
        repeat (300) step(1'($urandom), 1'($urandom));
        busy_random();
        repeat (3) step(1'b0, 1'b0);
        chk(exq.size() == 0, "outstanding", exq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Monitor: capture waveform while busy, score each completed sequence
    initial begin
        logic [1:0] ab;
        logic [1:0] prev = 2'b00;
        bit         have_prev = 1'b0;
        bit         pend = 1'b0;
        int         pend_cnt = 0;
        logic [1:0] cap[$];
        logic [1:0] ref_q[$];
        logic [1:0] ph[3];
        exp_t       e;
        bit         same;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rst_seen) begin
                    cap.delete();
                    pend      = 1'b0;
                    have_prev = 1'b0;
                    rst_seen  = 1'b0;
                end
                ab = {a, b};
                if (have_prev)
                    chk($countones(ab ^ prev) <= 1, "gray", int'(ab), int'(prev));
                prev      = ab;
                have_prev = 1'b1;
                if (pend) begin
                    chk(int'(exp_count) == pend_cnt, "exp_count", int'(exp_count), pend_cnt);
                    pend = 1'b0;
                end
                if (busy) cap.push_back(ab);
                else      cap.delete();
                if (done) begin
                    if (exq.size() == 0) begin
                        chk(1'b0, "spurious_done", 1, 0);
                    end else begin
                        e = exq.pop_front();
                        if (e.ex) begin ph[0] = 2'b01; ph[1] = 2'b11; ph[2] = 2'b10; end
                        else      begin ph[0] = 2'b10; ph[1] = 2'b11; ph[2] = 2'b01; end
                        ref_q.delete();
                        for (int p = 0; p < 3; p++)
                            for (int h = 0; h < H; h++) ref_q.push_back(ph[p]);
                        for (int g = 0; g < G; g++) ref_q.push_back(2'b00);
                        same = (cap.size() == ref_q.size());
                        if (same)
                            for (int i = 0; i < cap.size(); i++)
                                if (cap[i] !== ref_q[i]) same = 1'b0;
                        chk(same, e.ex ? "exit_wave_len" : "entry_wave_len",
                            cap.size(), ref_q.size());
                        pend     = 1'b1;
                        pend_cnt = e.cnt;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
